// File: rtl/sync_nflop_filt.sv
// Multi-bit N-stage synchroniser with a per-bit glitch filter and edge pulses.
// STAGES must be >= 2 and FILT_CYC >= 1; bits are resolved independently (no bus coherency).

module sync_nflop_lane #(
    parameter int   STAGES   = 2,
    parameter int   FILT_CYC = 1,
    parameter logic RST_BIT  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(FILT_CYC + 1);

    logic [STAGES-1:0] s_q, s_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              q_q, q_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              sync;

    assign sync = s_q[STAGES-1];

    always_comb begin
        s_d    = {s_q[STAGES-2:0], d};
        q_d    = q_q;
        cnt_d  = '0;
        // Any cycle where sync agrees with q drops all accumulated credit.
        if (sync != q_q) begin
            if (cnt_q == CW'(FILT_CYC - 1)) q_d = sync;
            else                            cnt_d = cnt_q + 1'b1;
        end
        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= {STAGES{RST_BIT}};
            q_q    <= RST_BIT;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;
endmodule

module sync_nflop_filt #(
    parameter int                   DATAWIDTH = 4,
    parameter int                   STAGES    = 2,
    parameter int                   FILT_CYC  = 1,
    parameter logic [DATAWIDTH-1:0] RST_VAL   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] d,
    output logic [DATAWIDTH-1:0] q,
    output logic [DATAWIDTH-1:0] rise,
    output logic [DATAWIDTH-1:0] fall
);
    for (genvar i = 0; i < DATAWIDTH; i++) begin : g_lane
        sync_nflop_lane #(
            .STAGES  (STAGES),
            .FILT_CYC(FILT_CYC),
            .RST_BIT (RST_VAL[i])
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .d   (d[i]),
            .q   (q[i]),
            .rise(rise[i]),
            .fall(fall[i])
        );
    end
endmodule

// File: tb/tb_sync_nflop_filt.sv
// Bench for sync_nflop_filt: three configurations (default, FILT_CYC=4, STAGES=3)
// driven cycle by cycle against hand-derived expected q/rise/fall sequences.

module tb_sync_nflop_filt;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, rst2;
    logic [3:0] d0, d1, d2;
    logic [3:0] q0, rise0, fall0;
    logic [3:0] q1, rise1, fall1;
    logic [3:0] q2, rise2, fall2;

    typedef struct {
        logic [3:0] q;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    sync_nflop_filt #(.DATAWIDTH(4), .STAGES(2), .FILT_CYC(1), .RST_VAL(4'h0)) u0 (
        .clk(clk), .rst(rst0), .d(d0), .q(q0), .rise(rise0), .fall(fall0));
    sync_nflop_filt #(.DATAWIDTH(4), .STAGES(2), .FILT_CYC(4), .RST_VAL(4'h0)) u1 (
        .clk(clk), .rst(rst1), .d(d1), .q(q1), .rise(rise1), .fall(fall1));
    sync_nflop_filt #(.DATAWIDTH(4), .STAGES(3), .FILT_CYC(1), .RST_VAL(4'h0)) u2 (
        .clk(clk), .rst(rst2), .d(d2), .q(q2), .rise(rise2), .fall(fall2));

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        d0 = 4'hF; d1 = 4'h0; d2 = 4'h0;
        for (int j = 0; j < 3; j++) begin
            sb.push_back('{4'h0, 4'h0, 4'h0});
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({q0, rise0, fall0} !== {e.q, e.rise, e.fall}) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got q=%h rise=%h fall=%h, want q=%h rise=%h fall=%h",
                         j, q0, rise0, fall0, e.q, e.rise, e.fall);
            end
        end
        checks++;
        if ({q1, rise1, fall1, q2, rise2, fall2} !== 24'h0) begin
            errors++;
            $display("FAIL reset_other: got %h, want 000000", {q1, rise1, fall1, q2, rise2, fall2});
        end
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        for (int j = 0; j < 5; j++) begin
            sb.push_back('{(j >= 2) ? 4'hF : 4'h0, (j == 2) ? 4'hF : 4'h0, 4'h0});
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({q0, rise0, fall0} !== {e.q, e.rise, e.fall}) begin
                errors++;
                $display("FAIL reset_release[%0d]: got q=%h rise=%h fall=%h, want q=%h rise=%h fall=%h",
                         j, q0, rise0, fall0, e.q, e.rise, e.fall);
            end
        end
    endtask

    task automatic test_latency();
        logic [3:0] from_v [3] = '{4'hF, 4'h0, 4'h5};
        logic [3:0] to_v   [3] = '{4'h0, 4'h5, 4'h0};
        for (int p = 0; p < 3; p++) begin
            d0 = to_v[p];
            for (int j = 0; j < 5; j++) begin
                sb.push_back('{(j >= 2) ? to_v[p] : from_v[p],
                               (j == 2) ? (to_v[p] & ~from_v[p]) : 4'h0,
                               (j == 2) ? (from_v[p] & ~to_v[p]) : 4'h0});
                @(posedge clk); #1;
                e = sb.pop_front(); checks++;
                if ({q0, rise0, fall0} !== {e.q, e.rise, e.fall}) begin
                    errors++;
                    $display("FAIL latency[%0d][%0d]: got q=%h rise=%h fall=%h, want q=%h rise=%h fall=%h",
                             p, j, q0, rise0, fall0, e.q, e.rise, e.fall);
                end
            end
        end
    endtask

    task automatic test_channels();
        d0 = 4'h2;
        for (int j = 0; j < 5; j++) begin
            sb.push_back('{(j >= 2) ? 4'h2 : 4'h0, (j == 2) ? 4'h2 : 4'h0, 4'h0});
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({q0, rise0, fall0} !== {e.q, e.rise, e.fall}) begin
                errors++;
                $display("FAIL channels_setup[%0d]: got q=%h rise=%h fall=%h, want q=%h rise=%h fall=%h",
                         j, q0, rise0, fall0, e.q, e.rise, e.fall);
            end
        end
        d0 = 4'h1;
        for (int j = 0; j < 5; j++) begin
            sb.push_back('{(j >= 2) ? 4'h1 : 4'h2, (j == 2) ? 4'h1 : 4'h0, (j == 2) ? 4'h2 : 4'h0});
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({q0, rise0, fall0} !== {e.q, e.rise, e.fall}) begin
                errors++;
                $display("FAIL channels[%0d]: got q=%h rise=%h fall=%h, want q=%h rise=%h fall=%h",
                         j, q0, rise0, fall0, e.q, e.rise, e.fall);
            end
        end
    endtask

    // One-cycle pulse on bit 2 with no filtering: rise and fall on consecutive cycles.
    task automatic test_back_to_back();
        for (int j = 0; j < 6; j++) begin
            d0 = (j == 0) ? 4'h5 : 4'h1;
            sb.push_back('{(j == 2) ? 4'h5 : 4'h1, (j == 2) ? 4'h4 : 4'h0, (j == 3) ? 4'h4 : 4'h0});
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({q0, rise0, fall0} !== {e.q, e.rise, e.fall}) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got q=%h rise=%h fall=%h, want q=%h rise=%h fall=%h",
                         j, q0, rise0, fall0, e.q, e.rise, e.fall);
            end
        end
    endtask

    task automatic test_filter();
        for (int j = 0; j < 10; j++) begin
            d1 = (j < 3) ? 4'h1 : 4'h0;
            sb.push_back('{4'h0, 4'h0, 4'h0});
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({q1, rise1, fall1} !== {e.q, e.rise, e.fall}) begin
                errors++;
                $display("FAIL filter_short[%0d]: got q=%h rise=%h fall=%h, want q=%h rise=%h fall=%h",
                         j, q1, rise1, fall1, e.q, e.rise, e.fall);
            end
        end
        for (int j = 0; j < 12; j++) begin
            d1 = (j < 4) ? 4'h1 : 4'h0;
            sb.push_back('{(j >= 5 && j <= 8) ? 4'h1 : 4'h0, (j == 5) ? 4'h1 : 4'h0, (j == 9) ? 4'h1 : 4'h0});
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({q1, rise1, fall1} !== {e.q, e.rise, e.fall}) begin
                errors++;
                $display("FAIL filter_full[%0d]: got q=%h rise=%h fall=%h, want q=%h rise=%h fall=%h",
                         j, q1, rise1, fall1, e.q, e.rise, e.fall);
            end
        end
    endtask

    // Reset lands on the edge where cnt[0] is 2; afterwards the full latency applies again.
    task automatic test_reset_mid();
        d1 = 4'h1;
        for (int j = 0; j < 12; j++) begin
            rst1 = (j == 4);
            sb.push_back('{(j >= 10) ? 4'h1 : 4'h0, (j == 10) ? 4'h1 : 4'h0, 4'h0});
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({q1, rise1, fall1} !== {e.q, e.rise, e.fall}) begin
                errors++;
                $display("FAIL reset_mid[%0d]: got q=%h rise=%h fall=%h, want q=%h rise=%h fall=%h",
                         j, q1, rise1, fall1, e.q, e.rise, e.fall);
            end
        end
        rst1 = 1'b0;
        d1 = 4'h0;
        for (int j = 0; j < 7; j++) begin
            sb.push_back('{(j < 5) ? 4'h1 : 4'h0, 4'h0, (j == 5) ? 4'h1 : 4'h0});
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({q1, rise1, fall1} !== {e.q, e.rise, e.fall}) begin
                errors++;
                $display("FAIL reset_mid_fall[%0d]: got q=%h rise=%h fall=%h, want q=%h rise=%h fall=%h",
                         j, q1, rise1, fall1, e.q, e.rise, e.fall);
            end
        end
    endtask

    task automatic test_depth();
        d2 = 4'h4;
        for (int j = 0; j < 6; j++) begin
            sb.push_back('{(j >= 3) ? 4'h4 : 4'h0, (j == 3) ? 4'h4 : 4'h0, 4'h0});
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({q2, rise2, fall2} !== {e.q, e.rise, e.fall}) begin
                errors++;
                $display("FAIL depth_rise[%0d]: got q=%h rise=%h fall=%h, want q=%h rise=%h fall=%h",
                         j, q2, rise2, fall2, e.q, e.rise, e.fall);
            end
        end
        d2 = 4'h0;
        for (int j = 0; j < 6; j++) begin
            sb.push_back('{(j >= 3) ? 4'h0 : 4'h4, 4'h0, (j == 3) ? 4'h4 : 4'h0});
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({q2, rise2, fall2} !== {e.q, e.rise, e.fall}) begin
                errors++;
                $display("FAIL depth_fall[%0d]: got q=%h rise=%h fall=%h, want q=%h rise=%h fall=%h",
                         j, q2, rise2, fall2, e.q, e.rise, e.fall);
            end
        end
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        d0 = 4'h0; d1 = 4'h0; d2 = 4'h0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_channels();
        test_back_to_back();
        test_filter();
        test_reset_mid();
        test_depth();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
